// File: rtl/mult_acc_pkg.sv
// Shared types and default widths for the multiply-accumulate consumer.
//   mac_state_t : controller states (IDLE waits for start, ACCUM sums products)
//   DEF_*       : default widths used by mult_accumulator
package mult_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } mac_state_t;

    localparam int DEF_PROD_W = 64;
    localparam int DEF_ACC_W  = 80;
    localparam int DEF_LEN_W  = 16;

endpackage

// File: rtl/mult_acc_result_reg.sv
// One-deep valid/ready holding register for completed sums.
//   clk, reset        : clock, synchronous active-low reset
//   commit            : a finished sum is presented this cycle
//   commit_sum/ovf    : the finished sum and its overflow flag
//   acc_ready         : consumer ready
//   clear_err         : clears err_overrun (wins over a same-cycle set)
//   acc_valid/out/ovf : held result, stable until acc_valid && acc_ready
//   err_overrun       : sticky, a commit was dropped because the register was full
module mult_acc_result_reg #(
    parameter int ACC_W = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit,
    input  logic [ACC_W-1:0] commit_sum,
    input  logic             commit_ovf,
    input  logic             acc_ready,
    input  logic             clear_err,
    output logic             acc_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output logic             err_overrun
);

    logic consume;
    logic drop;

    assign consume = acc_valid && acc_ready;
    // Register full and not draining this cycle: the new sum has nowhere to go.
    assign drop    = commit && acc_valid && !acc_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_valid   <= 1'b0;
            acc_out     <= '0;
            acc_ovf     <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            if (commit && !drop) begin
                // Covers both empty register and consume-and-refill in one cycle.
                acc_valid <= 1'b1;
                acc_out   <= commit_sum;
                acc_ovf   <= commit_ovf;
            end else if (consume) begin
                acc_valid <= 1'b0;
            end

            if (clear_err)
                err_overrun <= 1'b0;
            else if (drop)
                err_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/mult_accumulator.sv
// Sums a runtime-programmed number of consecutive multiplier products into a
// wide accumulator and hands each finished sum to a valid/ready result port.
//   clk, reset          : clock, synchronous active-low reset
//   start, len          : begin a vector of len products (ignored while busy)
//   busy                : vector in progress
//   prod_valid, prod    : multiplier output, no backpressure
//   acc_valid/ready/out : result handshake and sum
//   acc_ovf             : sum overflowed ACC_W, qualified by acc_valid
//   err_overrun         : sticky, a result was dropped on a full holding register
//   err_stray           : sticky, a product arrived outside a vector
//   clear_err           : clears both sticky flags
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter bit SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_ovf,
    output logic              err_overrun,
    output logic              err_stray,
    input  logic              clear_err
);

    mac_state_t       state, state_next;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             step_ovf;
    logic             ovf_sticky;
    logic             start_vec;
    logic             zero_start;
    logic             beat;
    logic             last_beat;
    logic             commit;
    logic [ACC_W-1:0] commit_sum;
    logic             commit_ovf;

    // Fill the upper bits first, then drop the product over the low bits;
    // this also works when ACC_W == PROD_W.
    always_comb begin
        prod_ext = (SIGNED && prod[PROD_W-1]) ? '1 : '0;
        prod_ext[PROD_W-1:0] = prod;
    end

    assign {carry, sum} = {1'b0, acc} + {1'b0, prod_ext};

    // Signed overflow: same-sign operands producing a result of the other sign.
    assign step_ovf = SIGNED ? ((acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                                (sum[ACC_W-1] != acc[ACC_W-1]))
                             : carry;

    assign start_vec  = (state == IDLE) && start && (len != '0);
    assign zero_start = (state == IDLE) && start && (len == '0);
    assign beat       = (state == ACCUM) && prod_valid;
    assign last_beat  = beat && (cnt == LEN_W'(1));

    assign commit     = zero_start || last_beat;
    assign commit_sum = last_beat ? sum : '0;
    assign commit_ovf = last_beat && (ovf_sticky || step_ovf);

    assign busy = (state == ACCUM);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_vec) state_next = ACCUM;
            ACCUM:   if (last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
        end else if (start_vec) begin
            acc        <= '0;
            cnt        <= len;
            ovf_sticky <= 1'b0;
        end else if (beat) begin
            acc        <= sum;
            cnt        <= cnt - LEN_W'(1);
            ovf_sticky <= ovf_sticky || step_ovf;
        end
    end

    // Products outside ACCUM (including the start cycle) are dropped and flagged.
    always_ff @(posedge clk) begin
        if (!reset)                          err_stray <= 1'b0;
        else if (clear_err)                  err_stray <= 1'b0;
        else if (state == IDLE && prod_valid) err_stray <= 1'b1;
    end

    mult_acc_result_reg #(
        .ACC_W(ACC_W)
    ) u_result (
        .clk        (clk),
        .reset      (reset),
        .commit     (commit),
        .commit_sum (commit_sum),
        .commit_ovf (commit_ovf),
        .acc_ready  (acc_ready),
        .clear_err  (clear_err),
        .acc_valid  (acc_valid),
        .acc_out    (acc_out),
        .acc_ovf    (acc_ovf),
        .err_overrun(err_overrun)
    );

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: three configurations driven by identical
// stimulus (unsigned/80, signed/80, unsigned/64) and checked every cycle
// against an arithmetic reference model.
module tb_mult_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        prod_valid = 1'b0;
    logic [63:0] prod = '0;
    logic        acc_ready = 1'b1;
    logic        clear_err = 1'b0;

    logic [2:0]  busy_o, valid_o, ovf_o, ovr_o, stray_o;
    logic [79:0] out_a, out_b;
    logic [63:0] out_c;

    always #5 clk = ~clk;

    mult_accumulator #(.PROD_W(64), .ACC_W(80), .LEN_W(16), .SIGNED(1'b0)) u_a (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy_o[0]),
        .prod_valid(prod_valid), .prod(prod), .acc_valid(valid_o[0]), .acc_ready(acc_ready),
        .acc_out(out_a), .acc_ovf(ovf_o[0]), .err_overrun(ovr_o[0]), .err_stray(stray_o[0]),
        .clear_err(clear_err));

    mult_accumulator #(.PROD_W(64), .ACC_W(80), .LEN_W(16), .SIGNED(1'b1)) u_b (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy_o[1]),
        .prod_valid(prod_valid), .prod(prod), .acc_valid(valid_o[1]), .acc_ready(acc_ready),
        .acc_out(out_b), .acc_ovf(ovf_o[1]), .err_overrun(ovr_o[1]), .err_stray(stray_o[1]),
        .clear_err(clear_err));

    mult_accumulator #(.PROD_W(64), .ACC_W(64), .LEN_W(16), .SIGNED(1'b0)) u_c (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy_o[2]),
        .prod_valid(prod_valid), .prod(prod), .acc_valid(valid_o[2]), .acc_ready(acc_ready),
        .acc_out(out_c), .acc_ovf(ovf_o[2]), .err_overrun(ovr_o[2]), .err_stray(stray_o[2]),
        .clear_err(clear_err));

    // ---------------- reference model ----------------
    int  cfg_w[3] = '{80, 80, 64};
    bit  cfg_s[3] = '{1'b0, 1'b1, 1'b0};

    bit                   m_busy, m_valid, m_overrun, m_stray;
    int                   m_rem;
    logic signed [127:0]  m_sum[3];   // true value, kept inside the ACC_W range
    bit                   m_vovf[3];
    logic [79:0]          m_out[3];
    bit                   m_rovf[3];

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rnd_rdy = 1'b0;
    logic [63:0] pq[$];

    function automatic logic signed [127:0] wmask(input int k);
        return (128'sd1 <<< cfg_w[k]) - 128'sd1;
    endfunction

    // Add one product in plain integer arithmetic, flag if the true sum leaves
    // the representable range, then wrap back into it.
    function automatic void addp(input int k, input logic [63:0] p);
        logic signed [127:0] e, t, lo, hi;
        e = cfg_s[k] ? {{64{p[63]}}, p} : {64'b0, p};
        t = m_sum[k] + e;
        if (cfg_s[k]) begin
            hi = (128'sd1 <<< (cfg_w[k] - 1)) - 128'sd1;
            lo = -(128'sd1 <<< (cfg_w[k] - 1));
        end else begin
            hi = wmask(k);
            lo = 128'sd0;
        end
        if (t < lo || t > hi) m_vovf[k] = 1'b1;
        t = t & wmask(k);
        if (cfg_s[k] && t > hi) t = t - (128'sd1 <<< cfg_w[k]);
        m_sum[k] = t;
    endfunction

    task automatic model_step;
        bit commit;
        if (!reset) begin
            m_busy = 0; m_valid = 0; m_overrun = 0; m_stray = 0; m_rem = 0;
            for (int k = 0; k < 3; k++) begin
                m_sum[k] = 0; m_vovf[k] = 0; m_out[k] = 0; m_rovf[k] = 0;
            end
        end else begin
            commit = 0;
            if (!m_busy) begin
                if (prod_valid && !clear_err) m_stray = 1;
                if (start) begin
                    for (int k = 0; k < 3; k++) begin m_sum[k] = 0; m_vovf[k] = 0; end
                    if (len == 0) commit = 1;
                    else begin m_busy = 1; m_rem = int'(len); end
                end
            end else if (prod_valid) begin
                for (int k = 0; k < 3; k++) addp(k, prod);
                m_rem--;
                if (m_rem == 0) begin commit = 1; m_busy = 0; end
            end
            if (commit) begin
                if (m_valid && !acc_ready) begin
                    if (!clear_err) m_overrun = 1;
                end else begin
                    m_valid = 1;
                    for (int k = 0; k < 3; k++) begin
                        m_out[k]  = 80'(m_sum[k] & wmask(k));
                        m_rovf[k] = m_vovf[k];
                    end
                end
            end else if (m_valid && acc_ready) begin
                m_valid = 0;
            end
            if (clear_err) begin m_overrun = 0; m_stray = 0; end
        end
    endtask

    // ---------------- checking ----------------
    function automatic logic [79:0] dut_out(input int k);
        case (k)
            0:       return out_a;
            1:       return out_b;
            default: return {16'h0, out_c};
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all;
        for (int k = 0; k < 3; k++) begin
            chk("busy",        k, 80'(busy_o[k]),  80'(m_busy));
            chk("acc_valid",   k, 80'(valid_o[k]), 80'(m_valid));
            chk("acc_out",     k, dut_out(k),      m_out[k]);
            chk("acc_ovf",     k, 80'(ovf_o[k]),   80'(m_rovf[k]));
            chk("err_overrun", k, 80'(ovr_o[k]),   80'(m_overrun));
            chk("err_stray",   k, 80'(stray_o[k]), 80'(m_stray));
        end
    endtask

    task automatic cyc;
        if (rnd_rdy) acc_ready = 1'($urandom_range(0, 1));
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [63:0] rnd_prod();
        case ($urandom_range(0, 3))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One vector of n products, gap idle cycles between beats.
    task automatic vec(input int n, input int gap);
        start = 1'b1; len = 16'(n);
        cyc();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) cyc();
            prod_valid = 1'b1;
            prod = (pq.size() != 0) ? pq.pop_front() : rnd_prod();
            cyc();
            prod_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1);
    end

    initial begin
        // reset
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();

        // len=4, 1..4 back-to-back: result valid the cycle after the 4th product
        pq = '{64'd1, 64'd2, 64'd3, 64'd4};
        vec(4, 0);
        chk("dir_sum4_valid", 0, 80'(valid_o[0]), 80'd1);
        chk("dir_sum4",       0, out_a,            80'd10);
        cyc();

        // gapped vector
        pq = '{64'd5, 64'd6, 64'd7};
        vec(3, 2);
        chk("dir_gap_sum", 0, out_a, 80'd18);
        cyc();

        // signed -5 + 3
        pq = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd3};
        vec(2, 0);
        chk("dir_signed", 1, out_b, 80'hFFFF_FFFF_FFFF_FFFF_FFFE);
        chk("dir_signed_ovf", 1, 80'(ovf_o[1]), 80'd0);
        cyc();

        // unsigned 64-bit wrap
        pq = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        vec(2, 0);
        chk("dir_wrap64",     2, {16'h0, out_c},   80'd0);
        chk("dir_wrap64_ovf", 2, 80'(ovf_o[2]),    80'd1);
        chk("dir_wide_sum",   0, out_a,            80'h1_0000_0000_0000_0000);
        cyc();

        // overrun: two results with the consumer stalled
        acc_ready = 1'b0;
        pq = '{64'd7};
        vec(1, 0);
        cyc();
        pq = '{64'd9};
        vec(1, 0);
        chk("dir_overrun",   0, 80'(ovr_o[0]), 80'd1);
        chk("dir_held_sum",  0, out_a,         80'd7);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        chk("dir_clear_err", 0, 80'(ovr_o[0]), 80'd0);
        acc_ready = 1'b1;
        cyc();

        // len=0
        start = 1'b1; len = 16'd0;
        cyc();
        start = 1'b0;
        chk("dir_len0_valid", 0, 80'(valid_o[0]), 80'd1);
        chk("dir_len0_sum",   0, out_a,            80'd0);
        cyc();

        // stray product in IDLE
        prod_valid = 1'b1; prod = 64'd5;
        cyc();
        prod_valid = 1'b0;
        chk("dir_stray", 0, 80'(stray_o[0]), 80'd1);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;

        // start while busy is ignored
        start = 1'b1; len = 16'd3;
        cyc();
        len = 16'd1; prod_valid = 1'b1; prod = 64'd1;
        cyc();
        start = 1'b0; prod = 64'd2;
        cyc();
        prod = 64'd3;
        cyc();
        prod_valid = 1'b0;
        chk("dir_busy_start", 0, out_a, 80'd6);
        cyc();

        // reset in the middle of a vector
        start = 1'b1; len = 16'd5;
        cyc();
        start = 1'b0; prod_valid = 1'b1; prod = 64'd11;
        repeat (2) cyc();
        prod_valid = 1'b0; reset = 1'b0;
        cyc();
        chk("dir_rst_busy", 0, 80'(busy_o[0]), 80'd0);
        chk("dir_rst_out",  0, out_a,          80'd0);
        reset = 1'b1;
        cyc();

        // randomized vectors with random consumer backpressure
        rnd_rdy = 1'b1;
        repeat (40) begin
            vec($urandom_range(1, 6), $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) cyc();
        end
        rnd_rdy = 1'b0;
        acc_ready = 1'b1;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
